// File: rtl/logic_unit_arbiter.sv
// logic_unit_arbiter: round-robin arbiter sharing one registered bitwise
// logic unit among NREQ requesters. The winner's opcode/operands are
// evaluated combinationally and captured in a single output register that
// also records the winner's id and an illegal-opcode flag.
//
// Handshake rules, request side and response side alike:
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   ready may depend combinationally on valid. A producer holds valid and its
//   payload stable until it sees ready. Dropping valid early only gives up
//   the slot. The response register keeps rsp_data/rsp_id/rsp_err stable
//   while rsp_valid=1 and rsp_ready=0.
module logic_unit_arbiter #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [3*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_data,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_err,
  output logic [15:0]           op_count
);

  localparam logic [2:0]  OP_OR   = 3'd0;
  localparam logic [2:0]  OP_AND  = 3'd1;
  localparam logic [2:0]  OP_XOR  = 3'd2;
  localparam logic [2:0]  OP_NOR  = 3'd3;
  localparam logic [2:0]  OP_NAND = 3'd4;
  localparam logic [2:0]  OP_XNOR = 3'd5;
  localparam logic [2:0]  OP_NOT  = 3'd6;
  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  // Registered state
  logic             rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0] rsp_data_q,  rsp_data_d;
  logic [IDW-1:0]   rsp_id_q,    rsp_id_d;
  logic             rsp_err_q,   rsp_err_d;
  logic [15:0]      op_count_q,  op_count_d;
  logic [IDW-1:0]   ptr_q,       ptr_d;

  // Arbitration results
  logic             found;
  logic [IDW-1:0]   grant_idx;
  logic [NREQ-1:0]  grant_vec;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             accept;
  logic             xfer;

  // Logic unit outputs
  logic [WIDTH-1:0] lu_data;
  logic             lu_err;

  // Output slot can take a new result when empty or being drained this cycle.
  assign accept = !rsp_valid_q || rsp_ready;

  // Round-robin search from ptr upward with wrap; also muxes the winner's payload.
  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    grant_idx = '0;
    sel_op    = '0;
    sel_a     = '0;
    sel_b     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found     = 1'b1;
        grant_idx = IDW'(idx);
        sel_op    = req_op[3*idx +: 3];
        sel_a     = req_a[WIDTH*idx +: WIDTH];
        sel_b     = req_b[WIDTH*idx +: WIDTH];
      end
    end
  end

  // One-hot grant, gated by slot availability and held low during reset.
  always_comb begin
    grant_vec = '0;
    if (found) grant_vec[grant_idx] = 1'b1;
    req_ready = (accept && !rst) ? grant_vec : '0;
  end

  assign xfer = found && accept && !rst;

  // Bitwise logic unit; opcode 7 is illegal and yields zero with the error flag.
  always_comb begin
    lu_data = '0;
    lu_err  = 1'b0;
    case (sel_op)
      OP_OR:   lu_data = sel_a | sel_b;
      OP_AND:  lu_data = sel_a & sel_b;
      OP_XOR:  lu_data = sel_a ^ sel_b;
      OP_NOR:  lu_data = ~(sel_a | sel_b);
      OP_NAND: lu_data = ~(sel_a & sel_b);
      OP_XNOR: lu_data = ~(sel_a ^ sel_b);
      OP_NOT:  lu_data = ~sel_a;
      default: begin
        lu_data = '0;
        lu_err  = 1'b1;
      end
    endcase
  end

  // Next-state: a transfer loads the result slot, advances the pointer and
  // bumps the saturating counter; otherwise a drain clears the valid flag.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    op_count_d  = op_count_q;
    ptr_d       = ptr_q;
    if (xfer) begin
      rsp_valid_d = 1'b1;
      rsp_data_d  = lu_data;
      rsp_id_d    = grant_idx;
      rsp_err_d   = lu_err;
      if (op_count_q != CNT_MAX) op_count_d = op_count_q + 16'd1;
      if (grant_idx == IDW'(NREQ - 1)) ptr_d = '0;
      else                             ptr_d = grant_idx + IDW'(1);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  // State registers with synchronous reset; a pending result is discarded.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      op_count_q  <= '0;
      ptr_q       <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      op_count_q  <= op_count_d;
      ptr_q       <= ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_logic_unit_arbiter.sv
// Directed bench for logic_unit_arbiter: reset, opcode sweep, round-robin,
// backpressure, illegal opcode, counter saturation and reset mid-operation.
// Inputs change on the falling edge; outputs are sampled #1 after an edge.
module tb_logic_unit_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;

  logic                  clk;
  logic                  rst;
  logic [NREQ-1:0]       req_valid;
  logic [3*NREQ-1:0]     req_op;
  logic [WIDTH*NREQ-1:0] req_a;
  logic [WIDTH*NREQ-1:0] req_b;
  logic [NREQ-1:0]       req_ready;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [WIDTH-1:0]      rsp_data;
  logic [IDW-1:0]        rsp_id;
  logic                  rsp_err;
  logic [15:0]           op_count;

  int pass_cnt;
  int total_cnt;

  logic [WIDTH-1:0] exp_q[$];

  logic_unit_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .op_count  (op_count)
  );

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req(input int i, input logic [2:0] op,
                         input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    req_op[3*i +: 3]       = op;
    req_a[WIDTH*i +: WIDTH] = a;
    req_b[WIDTH*i +: WIDTH] = b;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    #1;
    total_cnt++;
    if (req_ready !== 4'b0000) $display("FAIL reset_ready_during_rst got=%b exp=0000", req_ready);
    else pass_cnt++;
    @(posedge clk);
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0 || rsp_err !== 1'b0 || op_count !== 16'd0)
      $display("FAIL reset_outputs got v=%b d=%h id=%0d e=%b cnt=%h exp all 0",
               rsp_valid, rsp_data, rsp_id, rsp_err, op_count);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    #1;
    total_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL reset_first_grant got=%b exp=0001", req_ready);
    else pass_cnt++;
    req_valid = '0;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd0)
      $display("FAIL reset_idle got v=%b cnt=%h exp v=0 cnt=0000", rsp_valid, op_count);
    else pass_cnt++;
  endtask

  task automatic test_op_sweep();
    logic [WIDTH-1:0] exp_d;
    exp_q = '{8'hBD, 8'h24, 8'h99, 8'h42, 8'hDB, 8'h66, 8'h5A};
    rsp_ready = 1'b1;
    for (int op = 0; op < 7; op++) begin
      @(negedge clk);
      req_valid = 4'b0001;
      set_req(0, 3'(op), 8'hA5, 8'h3C);
      #1;
      total_cnt++;
      if (req_ready !== 4'b0001) $display("FAIL sweep_ready op=%0d got=%b exp=0001", op, req_ready);
      else pass_cnt++;
      @(posedge clk); #1;
      exp_d = exp_q.pop_front();
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_data !== exp_d || rsp_id !== 2'd0 || rsp_err !== 1'b0)
        $display("FAIL sweep_result op=%0d got v=%b d=%h id=%0d e=%b exp v=1 d=%h id=0 e=0",
                 op, rsp_valid, rsp_data, rsp_id, rsp_err, exp_d);
      else pass_cnt++;
    end
    @(negedge clk);
    req_valid = '0;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd7)
      $display("FAIL sweep_drain got v=%b cnt=%h exp v=0 cnt=0007", rsp_valid, op_count);
    else pass_cnt++;
  endtask

  // Pointer sits at 1 after the sweep, so the rotation starts at requester 1.
  task automatic test_round_robin();
    int exp_id;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 3'd2, 8'(8'h11 * (i + 1)), 8'h00);
    @(negedge clk);
    req_valid = '1;
    for (int c = 0; c < 8; c++) begin
      exp_id = (1 + c) % NREQ;
      #1;
      total_cnt++;
      if (req_ready !== 4'(1 << exp_id))
        $display("FAIL rr_ready cycle=%0d got=%b exp=%b", c, req_ready, 4'(1 << exp_id));
      else pass_cnt++;
      @(posedge clk); #1;
      total_cnt++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id) || rsp_data !== 8'(8'h11 * (exp_id + 1)))
        $display("FAIL rr_result cycle=%0d got v=%b id=%0d d=%h exp v=1 id=%0d d=%h",
                 c, rsp_valid, rsp_id, rsp_data, exp_id, 8'(8'h11 * (exp_id + 1)));
      else pass_cnt++;
      @(negedge clk);
    end
    req_valid = '0;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd15)
      $display("FAIL rr_drain got v=%b cnt=%h exp v=0 cnt=000f", rsp_valid, op_count);
    else pass_cnt++;
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'b0010;
    set_req(1, 3'd2, 8'h0F, 8'hFF);
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'hF0 || rsp_id !== 2'd1)
      $display("FAIL bp_first got v=%b d=%h id=%0d exp v=1 d=f0 id=1", rsp_valid, rsp_data, rsp_id);
    else pass_cnt++;
    @(negedge clk);
    rsp_ready = 1'b0;
    set_req(1, 3'd1, 8'h33, 8'h0F);
    for (int c = 0; c < 5; c++) begin
      #1;
      total_cnt++;
      if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_data !== 8'hF0 || rsp_id !== 2'd1)
        $display("FAIL bp_hold cycle=%0d got rdy=%b v=%b d=%h id=%0d exp rdy=0000 v=1 d=f0 id=1",
                 c, req_ready, rsp_valid, rsp_data, rsp_id);
      else pass_cnt++;
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    #1;
    total_cnt++;
    if (req_ready !== 4'b0010) $display("FAIL bp_release_ready got=%b exp=0010", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_data !== 8'h03 || rsp_id !== 2'd1 || op_count !== 16'd17)
      $display("FAIL bp_second got v=%b d=%h id=%0d cnt=%h exp v=1 d=03 id=1 cnt=0011",
               rsp_valid, rsp_data, rsp_id, op_count);
    else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
  endtask

  // Pointer sits at 2; illegal op from req2 then a legal one from req3 back-to-back.
  task automatic test_illegal_op();
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 4'b0100;
    set_req(2, 3'd7, 8'hFF, 8'hFF);
    #1;
    total_cnt++;
    if (req_ready !== 4'b0100) $display("FAIL illegal_ready got=%b exp=0100", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== 8'h00 || rsp_id !== 2'd2 || op_count !== 16'd18)
      $display("FAIL illegal_result got v=%b e=%b d=%h id=%0d cnt=%h exp v=1 e=1 d=00 id=2 cnt=0012",
               rsp_valid, rsp_err, rsp_data, rsp_id, op_count);
    else pass_cnt++;
    @(negedge clk);
    req_valid = 4'b1000;
    set_req(3, 3'd0, 8'h01, 8'h02);
    #1;
    total_cnt++;
    if (req_ready !== 4'b1000) $display("FAIL b2b_ready got=%b exp=1000", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b0 || rsp_data !== 8'h03 || rsp_id !== 2'd3 || op_count !== 16'd19)
      $display("FAIL b2b_result got v=%b e=%b d=%h id=%0d cnt=%h exp v=1 e=0 d=03 id=3 cnt=0013",
               rsp_valid, rsp_err, rsp_data, rsp_id, op_count);
    else pass_cnt++;
    @(negedge clk);
    req_valid = '0;
    @(posedge clk);
  endtask

  task automatic test_saturation();
    rsp_ready = 1'b1;
    set_req(0, 3'd0, 8'h01, 8'h00);
    @(negedge clk);
    req_valid = 4'b0001;
    repeat (65534 - 19) @(negedge clk);
    req_valid = '0;
    #1;
    total_cnt++;
    if (op_count !== 16'hFFFE) $display("FAIL sat_preload got=%h exp=fffe", op_count);
    else pass_cnt++;
    @(negedge clk);
    req_valid = 4'b0001;
    repeat (3) @(negedge clk);
    req_valid = '0;
    #1;
    total_cnt++;
    if (op_count !== 16'hFFFF || rsp_valid !== 1'b1)
      $display("FAIL sat_hold got cnt=%h v=%b exp cnt=ffff v=1", op_count, rsp_valid);
    else pass_cnt++;
  endtask

  // Result is still pending here; reset must drop it and restart the rotation.
  task automatic test_reset_mid_op();
    rsp_ready = 1'b0;
    rst = 1'b1;
    req_valid = '1;
    #1;
    total_cnt++;
    if (req_ready !== 4'b0000) $display("FAIL rst_mid_ready got=%b exp=0000", req_ready);
    else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++;
    if (rsp_valid !== 1'b0 || op_count !== 16'd0 || rsp_data !== 8'h00)
      $display("FAIL rst_mid_state got v=%b cnt=%h d=%h exp v=0 cnt=0000 d=00", rsp_valid, op_count, rsp_data);
    else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    rsp_ready = 1'b1;
    #1;
    total_cnt++;
    if (req_ready !== 4'b0001) $display("FAIL rst_mid_grant got=%b exp=0001", req_ready);
    else pass_cnt++;
    req_valid = '0;
    @(posedge clk);
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst       = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_op_sweep();
    test_round_robin();
    test_backpressure();
    test_illegal_op();
    test_saturation();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
